bcd_xs3_seq_ctrl: RTL and testbench

Sequencer that converts a multi-digit packed BCD word to packed Excess-3. It time-shares one external 4-bit BCD_Excess_3 combinational converter, feeding one digit per clock, least-significant digit first. It reassembles the results and returns them through valid/ready handshakes. It sits between a BCD-producing upstream, such as a counter or keypad front end, and an Excess-3 consumer, such as a self-complementing adder or display path.

---
 rtl/bcd_xs3_seq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_bcd_xs3_seq_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_xs3_seq_ctrl.sv
// bcd_xs3_seq_ctrl: converts a packed BCD word to packed Excess-3 by feeding
// one digit per clock (LSD first) through a shared external 4-bit converter,
// then presents the reassembled result on a valid/ready output handshake.
// Digits above 9 are written as 4'b0000 and flagged in digit_err.
module bcd_xs3_seq_ctrl #(
  parameter int DIGITS = 4,
  parameter int IDX_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [3:0]            conv_in,
  input  logic [3:0]            conv_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   xs3_out,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True when a 4-bit code is a legal BCD digit (0..9).
  function automatic logic digit_is_bcd(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*DIGITS-1:0]   in_reg_q, in_reg_d;
  logic [4*DIGITS-1:0]   xs3_q, xs3_d;
  logic [DIGITS-1:0]     err_q, err_d;

  logic                  accept_s;
  logic                  out_hs_s;
  logic                  last_digit_s;
  logic [3:0]            cur_digit_s;
  logic                  cur_ok_s;

  // Handshake qualifiers and the digit currently addressed by the index.
  always_comb begin
    accept_s     = (state_q == ST_IDLE) && in_valid;
    out_hs_s     = (state_q == ST_DONE) && out_ready;
    last_digit_s = (idx_q == IDX_W'(DIGITS - 1));
    cur_digit_s  = in_reg_q[4*int'(idx_q) +: 4];
    cur_ok_s     = digit_is_bcd(cur_digit_s);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> CONV on accept, CONV -> DONE on last digit,
  // DONE -> IDLE on the output handshake (no accept on that same edge).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_CONV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONV: begin
        if (last_digit_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CONV;
        end
      end
      ST_DONE: begin
        if (out_hs_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from state; conv_in only carries a digit while converting.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    if (state_q == ST_CONV) begin
      conv_in = cur_digit_s;
    end else begin
      conv_in = 4'b0000;
    end
  end

  // Datapath next values: capture on accept, write one result digit per CONV edge.
  always_comb begin
    in_reg_d = in_reg_q;
    idx_d    = idx_q;
    xs3_d    = xs3_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          in_reg_d = bcd_in;
          idx_d    = '0;
          xs3_d    = '0;
          err_d    = '0;
        end else begin
          in_reg_d = in_reg_q;
        end
      end
      ST_CONV: begin
        if (cur_ok_s) begin
          xs3_d[4*int'(idx_q) +: 4] = conv_out;
        end else begin
          // Converter output is meaningless for non-BCD codes; flag and zero.
          xs3_d[4*int'(idx_q) +: 4] = 4'b0000;
          err_d[int'(idx_q)]        = 1'b1;
        end
        if (last_digit_s) begin
          idx_d = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        idx_d = idx_q;
      end
      default: begin
        idx_d = '0;
      end
    endcase
  end

  // Datapath registers; results persist after the handshake until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_reg_q <= '0;
      idx_q    <= '0;
      xs3_q    <= '0;
      err_q    <= '0;
    end else begin
      in_reg_q <= in_reg_d;
      idx_q    <= idx_d;
      xs3_q    <= xs3_d;
      err_q    <= err_d;
    end
  end

  assign xs3_out   = xs3_q;
  assign digit_err = err_q;

endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// Self-checking bench for bcd_xs3_seq_ctrl (DIGITS=4): directed cases plus
// randomized words checked against a digit-by-digit arithmetic reference.
module tb_bcd_xs3_seq_ctrl;

  localparam int DIGITS = 4;
  localparam int IDX_W  = 3;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] bcd_in;
  logic [3:0]          conv_in;
  logic [3:0]          conv_out;
  logic                out_valid;
  logic                out_ready;
  logic [4*DIGITS-1:0] xs3_out;
  logic [DIGITS-1:0]   digit_err;
  logic                busy;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;

  bcd_xs3_seq_ctrl #(.DIGITS(DIGITS), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .conv_in   (conv_in),
    .conv_out  (conv_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xs3_out   (xs3_out),
    .digit_err (digit_err),
    .busy      (busy)
  );

  // External shared converter: value+3 for BCD, junk for illegal codes.
  assign conv_out = (conv_in <= 4'd9) ? (conv_in + 4'd3) : 4'b1110;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completed output handshakes.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: each digit independently, value+3 or zero-with-error.
  task automatic model(input logic [15:0] w, output logic [15:0] ex, output logic [3:0] ee);
    int d;
    ex = 16'h0000;
    ee = 4'b0000;
    for (int k = 0; k < DIGITS; k++) begin
      d = (int'(w) >> (4 * k)) & 15;
      if (d > 9) ee = ee | 4'(1 << k);
      else ex = ex | 16'((d + 3) << (4 * k));
    end
  endtask

  // One full transaction: accept, DIGITS conversion edges, optional stall, handshake.
  task automatic run_word(input logic [15:0] w, input int stall, input bit hold);
    logic [15:0] ex;
    logic [3:0]  ee;
    int          hs0;
    model(w, ex, ee);
    check_eq("idle_in_ready", 32'(in_ready), 32'd1);
    bcd_in    = w;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    tick();
    check_eq("acc_busy", 32'(busy), 32'd1);
    check_eq("acc_in_ready", 32'(in_ready), 32'd0);
    check_eq("acc_clear_xs3", 32'(xs3_out), 32'd0);
    check_eq("acc_clear_err", 32'(digit_err), 32'd0);
    in_valid = hold;
    for (int i = 0; i < DIGITS; i++) begin
      check_eq("conv_in_seq", 32'(conv_in), (32'(w) >> (4 * i)) & 32'hF);
      check_eq("conv_no_valid", 32'(out_valid), 32'd0);
      if (hold) bcd_in = 16'($urandom);
      tick();
    end
    hs0 = hs_cnt;
    check_eq("done_valid", 32'(out_valid), 32'd1);
    check_eq("done_xs3", 32'(xs3_out), 32'(ex));
    check_eq("done_err", 32'(digit_err), 32'(ee));
    check_eq("done_conv_in", 32'(conv_in), 32'd0);
    for (int s = 0; s < stall; s++) begin
      tick();
      check_eq("stall_valid", 32'(out_valid), 32'd1);
      check_eq("stall_xs3", 32'(xs3_out), 32'(ex));
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("post_valid", 32'(out_valid), 32'd0);
    check_eq("post_in_ready", 32'(in_ready), 32'd1);
    check_eq("post_busy", 32'(busy), 32'd0);
    check_eq("post_hold_xs3", 32'(xs3_out), 32'(ex));
    check_eq("post_hold_err", 32'(digit_err), 32'(ee));
    check_eq("one_handshake", 32'(hs_cnt), 32'(hs0 + 1));
    in_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_xs3"}, 32'(xs3_out), 32'd0);
    check_eq({tag, "_err"}, 32'(digit_err), 32'd0);
    check_eq({tag, "_conv_in"}, 32'(conv_in), 32'd0);
  endtask

  initial begin
    logic [15:0] w;
    int          hs_before;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bcd_in    = 16'h0000;
    #3;
    check_reset_state("rst0");
    tick();
    rst = 1'b0;
    tick();
    check_reset_state("rst1");

    // Directed cases.
    run_word(16'h1234, 0, 1'b0);
    run_word(16'h0000, 0, 1'b0);
    run_word(16'h9999, 1, 1'b0);
    run_word(16'h12A4, 0, 1'b0);
    run_word(16'hFFFF, 2, 1'b0);
    run_word(16'h5678, 10, 1'b1);
    run_word(16'h5678, 0, 1'b0);

    // Abort mid-conversion with an asynchronous reset.
    hs_before = hs_cnt;
    bcd_in    = 16'h4321;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("abort");
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < DIGITS + 2; i++) begin
      check_eq("abort_no_valid", 32'(out_valid), 32'd0);
      tick();
    end
    check_eq("abort_no_hs", 32'(hs_cnt), 32'(hs_before));
    out_ready = 1'b0;
    run_word(16'h0987, 0, 1'b0);

    // Hold-off: in_valid pulsed and bcd_in changed during the conversion.
    run_word(16'h2468, 0, 1'b1);

    // Randomized words, stalls and hold-off.
    for (int n = 0; n < 40; n++) begin
      w = 16'h0000;
      for (int k = 0; k < DIGITS; k++) begin
        if ($urandom_range(0, 99) < 85) w[4*k +: 4] = 4'($urandom_range(0, 9));
        else w[4*k +: 4] = 4'($urandom_range(10, 15));
      end
      run_word(w, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
